// File: rtl/ddr4_iod_dly_ctrl.sv
// ---------------------------------------------------------------------------
// ddr4_iod_dly_ctrl
//   Fabric-side initiator for the dynamic delay-line control port of one DDR4
//   PHY IOD lane. It takes LOAD / INC / DEC / NOP commands from training logic
//   over a valid/ready handshake and drives DELAY_LINE_LOAD/MOVE/DIRECTION.
//   It tracks the current tap and reports completion and range errors.
//
//   Optional feature macro: DDR4_IOD_DLY_OOR_SYNC_EN
//     When defined, DELAY_LINE_OUT_OF_RANGE_0 is passed through a 2-flop
//     synchroniser and every settle window is lengthened by 2 cycles.
//     When undefined, the range flag is sampled directly.
//
// Ports
//   FAB_CLK                   fabric clock (same as IOD TX_CLK), rising edge
//   ARST_N                    asynchronous active-low reset
//   CMD_VALID / CMD_READY     command handshake (READY high in IDLE only)
//   CMD_OP                    00 LOAD, 01 INC, 10 DEC, 11 NOP
//   CMD_COUNT                 number of taps for INC/DEC
//   DONE                      one-cycle completion pulse
//   ERR                       sticky range error for the last command
//   TAP_VAL                   tracked tap value
//   DELAY_LINE_LOAD_0         load pulse to IOD
//   DELAY_LINE_MOVE_0         move pulse to IOD
//   DELAY_LINE_DIRECTION_0    1 = increase delay, 0 = decrease
//   DELAY_LINE_OUT_OF_RANGE_0 IOD range flag
// ---------------------------------------------------------------------------
module ddr4_iod_dly_ctrl #(
  parameter int TAP_W      = 8,
  parameter int MAX_TAP    = 255,
  parameter int INIT_TAP   = 1,
  parameter int SETTLE_CYC = 4
) (
  input  logic             FAB_CLK,
  input  logic             ARST_N,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [TAP_W-1:0] CMD_COUNT,
  output logic             DONE,
  output logic             ERR,
  output logic [TAP_W-1:0] TAP_VAL,
  output logic             DELAY_LINE_LOAD_0,
  output logic             DELAY_LINE_MOVE_0,
  output logic             DELAY_LINE_DIRECTION_0,
  input  logic             DELAY_LINE_OUT_OF_RANGE_0
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD_ST   = 3'd1;
  localparam logic [2:0] DIR_ST    = 3'd2;
  localparam logic [2:0] MOVE_ST   = 3'd3;
  localparam logic [2:0] SETTLE_ST = 3'd4;
  localparam logic [2:0] DONE_ST   = 3'd5;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;

`ifdef DDR4_IOD_DLY_OOR_SYNC_EN
  localparam int SETTLE_EXTRA = 2;
`else
  localparam int SETTLE_EXTRA = 0;
`endif

  // Settle counter is loaded with (window - 1) and runs down to zero, so the
  // window length in cycles equals SETTLE_CYC (+2 with the synchroniser).
  localparam logic [4:0]       SETTLE_LD  = 5'(SETTLE_CYC + SETTLE_EXTRA - 1);
  localparam logic [TAP_W-1:0] INIT_TAP_V = TAP_W'(INIT_TAP);
  localparam logic [TAP_W:0]   MAX_TAP_V  = (TAP_W+1)'(MAX_TAP);
  localparam logic [TAP_W-1:0] TAP_ZERO   = TAP_W'(0);
  localparam logic [TAP_W-1:0] TAP_ONE    = TAP_W'(1);

  // One tap step up or down.
  function automatic logic [TAP_W-1:0] tap_step(input logic [TAP_W-1:0] t,
                                                input logic up);
    logic [TAP_W-1:0] r;
    if (up) begin
      r = t + TAP_ONE;
    end else begin
      r = t - TAP_ONE;
    end
    return r;
  endfunction

  logic [2:0]       state_r,  state_nx_s;
  logic [TAP_W-1:0] tap_r,    tap_nx_s;
  logic [TAP_W-1:0] rem_r,    rem_nx_s;
  logic [4:0]       cnt_r,    cnt_nx_s;
  logic             dir_r,    dir_nx_s;
  logic             err_r,    err_nx_s;
  logic             after_load_r, after_load_nx_s;
  logic             ready_r, done_r, load_r, move_r;
  logic [TAP_W:0]   inc_sum_s;
  logic             oor_s;

`ifdef DDR4_IOD_DLY_OOR_SYNC_EN
  logic oor_meta_r, oor_sync_r;

  // Two-flop synchroniser for the IOD range flag.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      oor_meta_r <= 1'b0;
      oor_sync_r <= 1'b0;
    end else begin
      oor_meta_r <= DELAY_LINE_OUT_OF_RANGE_0;
      oor_sync_r <= oor_meta_r;
    end
  end

  assign oor_s = oor_sync_r;
`else
  assign oor_s = DELAY_LINE_OUT_OF_RANGE_0;
`endif

  // INC range check is done one bit wider so the sum cannot wrap.
  assign inc_sum_s = {1'b0, tap_r} + {1'b0, CMD_COUNT};

  // Next-state and next-value logic for the command sequencer.
  always_comb begin
    state_nx_s      = state_r;
    tap_nx_s        = tap_r;
    rem_nx_s        = rem_r;
    cnt_nx_s        = cnt_r;
    dir_nx_s        = dir_r;
    err_nx_s        = err_r;
    after_load_nx_s = after_load_r;
    case (state_r)
      IDLE: begin
        if (CMD_VALID && ready_r) begin
          err_nx_s = 1'b0;
          case (CMD_OP)
            OP_LOAD: begin
              state_nx_s      = LOAD_ST;
              tap_nx_s        = INIT_TAP_V;
              after_load_nx_s = 1'b1;
            end
            OP_INC: begin
              if (CMD_COUNT == TAP_ZERO) begin
                state_nx_s = DONE_ST;
              end else if (inc_sum_s > MAX_TAP_V) begin
                state_nx_s = DONE_ST;
                err_nx_s   = 1'b1;
              end else begin
                state_nx_s      = DIR_ST;
                dir_nx_s        = 1'b1;
                rem_nx_s        = CMD_COUNT;
                after_load_nx_s = 1'b0;
              end
            end
            OP_DEC: begin
              if (CMD_COUNT == TAP_ZERO) begin
                state_nx_s = DONE_ST;
              end else if (CMD_COUNT > tap_r) begin
                state_nx_s = DONE_ST;
                err_nx_s   = 1'b1;
              end else begin
                state_nx_s      = DIR_ST;
                dir_nx_s        = 1'b0;
                rem_nx_s        = CMD_COUNT;
                after_load_nx_s = 1'b0;
              end
            end
            default: begin
              state_nx_s = DONE_ST;
            end
          endcase
        end else begin
          state_nx_s = IDLE;
        end
      end
      LOAD_ST: begin
        state_nx_s = SETTLE_ST;
        cnt_nx_s   = SETTLE_LD;
      end
      // Tap and remaining count update as the MOVE pulse is issued so that
      // TAP_VAL already reflects the step during the pulse cycle.
      DIR_ST: begin
        state_nx_s = MOVE_ST;
        tap_nx_s   = tap_step(tap_r, dir_r);
        rem_nx_s   = rem_r - TAP_ONE;
      end
      MOVE_ST: begin
        state_nx_s = SETTLE_ST;
        cnt_nx_s   = SETTLE_LD;
      end
      SETTLE_ST: begin
        if (cnt_r != 5'd0) begin
          cnt_nx_s = cnt_r - 5'd1;
        end else if (!after_load_r && oor_s) begin
          // IOD saturated: the last step did not happen, so take it back.
          state_nx_s = DONE_ST;
          err_nx_s   = 1'b1;
          tap_nx_s   = tap_step(tap_r, !dir_r);
          rem_nx_s   = TAP_ZERO;
        end else if (rem_r != TAP_ZERO) begin
          state_nx_s = MOVE_ST;
          tap_nx_s   = tap_step(tap_r, dir_r);
          rem_nx_s   = rem_r - TAP_ONE;
        end else begin
          state_nx_s = DONE_ST;
        end
      end
      DONE_ST: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, tracked values and registered outputs. Pulse outputs are decoded
  // from the next state so that they line up exactly with the state cycle.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_r      <= IDLE;
      tap_r        <= INIT_TAP_V;
      rem_r        <= TAP_ZERO;
      cnt_r        <= 5'd0;
      dir_r        <= 1'b0;
      err_r        <= 1'b0;
      after_load_r <= 1'b0;
      ready_r      <= 1'b0;
      done_r       <= 1'b0;
      load_r       <= 1'b0;
      move_r       <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      tap_r        <= tap_nx_s;
      rem_r        <= rem_nx_s;
      cnt_r        <= cnt_nx_s;
      dir_r        <= dir_nx_s;
      err_r        <= err_nx_s;
      after_load_r <= after_load_nx_s;
      ready_r      <= (state_nx_s == IDLE);
      done_r       <= (state_nx_s == DONE_ST);
      load_r       <= (state_nx_s == LOAD_ST);
      move_r       <= (state_nx_s == MOVE_ST);
    end
  end

  assign CMD_READY              = ready_r;
  assign DONE                   = done_r;
  assign ERR                    = err_r;
  assign TAP_VAL                = tap_r;
  assign DELAY_LINE_LOAD_0      = load_r;
  assign DELAY_LINE_MOVE_0      = move_r;
  assign DELAY_LINE_DIRECTION_0 = dir_r;

endmodule

// File: tb/tb_ddr4_iod_dly_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ddr4_iod_dly_ctrl
//   Self-checking bench for ddr4_iod_dly_ctrl: a table of directed commands
//   with hand-computed results, plus hand-written sequences for reset,
//   mid-operation reset and back-to-back commands with CMD_VALID held high.
// ---------------------------------------------------------------------------
module tb_ddr4_iod_dly_ctrl;

`ifdef DDR4_IOD_DLY_OOR_SYNC_EN
  localparam int SC = 6;
`else
  localparam int SC = 4;
`endif

  logic       FAB_CLK;
  logic       ARST_N;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [1:0] CMD_OP;
  logic [7:0] CMD_COUNT;
  logic       DONE;
  logic       ERR;
  logic [7:0] TAP_VAL;
  logic       DELAY_LINE_LOAD_0;
  logic       DELAY_LINE_MOVE_0;
  logic       DELAY_LINE_DIRECTION_0;
  logic       DELAY_LINE_OUT_OF_RANGE_0;

  ddr4_iod_dly_ctrl dut (
    .FAB_CLK                   (FAB_CLK),
    .ARST_N                    (ARST_N),
    .CMD_VALID                 (CMD_VALID),
    .CMD_READY                 (CMD_READY),
    .CMD_OP                    (CMD_OP),
    .CMD_COUNT                 (CMD_COUNT),
    .DONE                      (DONE),
    .ERR                       (ERR),
    .TAP_VAL                   (TAP_VAL),
    .DELAY_LINE_LOAD_0         (DELAY_LINE_LOAD_0),
    .DELAY_LINE_MOVE_0         (DELAY_LINE_MOVE_0),
    .DELAY_LINE_DIRECTION_0    (DELAY_LINE_DIRECTION_0),
    .DELAY_LINE_OUT_OF_RANGE_0 (DELAY_LINE_OUT_OF_RANGE_0)
  );

  initial FAB_CLK = 1'b0;
  always #5 FAB_CLK = ~FAB_CLK;

  typedef struct {
    logic [1:0] op;
    int         count;
    int         oor_after;  // raise OUT_OF_RANGE at this MOVE pulse (0 = never)
    int         exp_tap;
    int         exp_err;
    int         exp_moves;
    int         exp_loads;
    int         exp_lat;    // cycles from acceptance to DONE
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issue one command and observe it through to DONE (sampled on negedges).
  task automatic run_cmd(input vec_t v, input int idx);
    int  cyc, moves, loads, lat, dir_bad, overlap, wait_c;
    bit  done_seen;
    string nm;
    nm = $sformatf("v%0d", idx);
    wait_c = 0;
    while (CMD_READY !== 1'b1 && wait_c < 50) begin
      @(negedge FAB_CLK);
      wait_c++;
    end
    chk({nm, "_ready_idle"}, int'(CMD_READY), 1);
    CMD_VALID = 1'b1;
    CMD_OP    = v.op;
    CMD_COUNT = 8'(v.count);
    @(negedge FAB_CLK);
    // Scramble inputs after acceptance: the DUT must have captured them.
    CMD_VALID = 1'b0;
    CMD_OP    = 2'b11;
    CMD_COUNT = 8'hA5;
    chk({nm, "_ready_busy"}, int'(CMD_READY), 0);
    cyc = 1; moves = 0; loads = 0; lat = -1; dir_bad = 0; overlap = 0;
    done_seen = 1'b0;
    while (!done_seen && cyc <= 3000) begin
      if (DELAY_LINE_LOAD_0 && DELAY_LINE_MOVE_0) overlap++;
      if (DELAY_LINE_LOAD_0) loads++;
      if (DELAY_LINE_MOVE_0) begin
        moves++;
        if (DELAY_LINE_DIRECTION_0 !== (v.op == 2'b01)) dir_bad++;
        if (moves == v.oor_after) DELAY_LINE_OUT_OF_RANGE_0 = 1'b1;
      end
      if (DONE === 1'b1) begin
        done_seen = 1'b1;
        lat = cyc;
      end else begin
        @(negedge FAB_CLK);
        cyc++;
      end
    end
    chk({nm, "_latency"}, lat, v.exp_lat);
    chk({nm, "_moves"}, moves, v.exp_moves);
    chk({nm, "_loads"}, loads, v.exp_loads);
    chk({nm, "_dir_bad"}, dir_bad, 0);
    chk({nm, "_overlap"}, overlap, 0);
    chk({nm, "_tap"}, int'(TAP_VAL), v.exp_tap);
    chk({nm, "_err"}, int'(ERR), v.exp_err);
    @(negedge FAB_CLK);
    DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
    chk({nm, "_done_width"}, int'(DONE), 0);
    chk({nm, "_ready_back"}, int'(CMD_READY), 1);
    chk({nm, "_err_sticky"}, int'(ERR), v.exp_err);
  endtask

  int start_tap, acc, dn, mv, ovl, k;
  int acc_idx [2];
  int done_idx [2];

  initial begin
    vecs[0]  = '{2'b00, 0,   0, 1,   0, 0,   1, 2 + SC};
    vecs[1]  = '{2'b01, 3,   0, 4,   0, 3,   0, 2 + 3 * (1 + SC)};
    vecs[2]  = '{2'b10, 5,   0, 4,   1, 0,   0, 1};
    vecs[3]  = '{2'b11, 0,   0, 4,   0, 0,   0, 1};
    vecs[4]  = '{2'b10, 3,   0, 1,   0, 3,   0, 2 + 3 * (1 + SC)};
    vecs[5]  = '{2'b01, 0,   0, 1,   0, 0,   0, 1};
    vecs[6]  = '{2'b01, 255, 0, 1,   1, 0,   0, 1};
    vecs[7]  = '{2'b01, 254, 0, 255, 0, 254, 0, 2 + 254 * (1 + SC)};
    vecs[8]  = '{2'b01, 1,   0, 255, 1, 0,   0, 1};
    vecs[9]  = '{2'b10, 255, 0, 0,   0, 255, 0, 2 + 255 * (1 + SC)};
    vecs[10] = '{2'b10, 1,   0, 0,   1, 0,   0, 1};
    vecs[11] = '{2'b00, 0,   0, 1,   0, 0,   1, 2 + SC};
    vecs[12] = '{2'b01, 9,   0, 10,  0, 9,   0, 2 + 9 * (1 + SC)};
    vecs[13] = '{2'b01, 4,   2, 11,  1, 2,   0, 2 + 2 * (1 + SC)};
    vecs[14] = '{2'b00, 0,   0, 1,   0, 0,   1, 2 + SC};

    ARST_N = 1'b0;
    CMD_VALID = 1'b0;
    CMD_OP = 2'b11;
    CMD_COUNT = 8'd0;
    DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;

    // Reset state.
    #12;
    chk("rst_ready", int'(CMD_READY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_err", int'(ERR), 0);
    chk("rst_tap", int'(TAP_VAL), 1);
    chk("rst_load", int'(DELAY_LINE_LOAD_0), 0);
    chk("rst_move", int'(DELAY_LINE_MOVE_0), 0);
    chk("rst_dir", int'(DELAY_LINE_DIRECTION_0), 0);
    @(negedge FAB_CLK);
    ARST_N = 1'b1;
    @(negedge FAB_CLK);
    chk("rst_ready_after", int'(CMD_READY), 1);

    for (int i = 0; i < NV; i++) begin
      run_cmd(vecs[i], i);
    end

    // Back-to-back INC 1 then DEC 1 with CMD_VALID held high.
    start_tap = int'(TAP_VAL);
    @(posedge FAB_CLK);
    #1;
    CMD_VALID = 1'b1;
    CMD_OP    = 2'b01;
    CMD_COUNT = 8'd1;
    acc = 0; dn = 0; mv = 0; ovl = 0; k = 0;
    acc_idx[0] = -1; acc_idx[1] = -1; done_idx[0] = -1; done_idx[1] = -1;
    while (dn < 2 && k < 200) begin
      @(negedge FAB_CLK);
      if (DELAY_LINE_LOAD_0 && DELAY_LINE_MOVE_0) ovl++;
      if (DELAY_LINE_MOVE_0) mv++;
      if (DONE === 1'b1 && dn < 2) begin
        done_idx[dn] = k;
        dn++;
      end
      if (CMD_READY === 1'b1 && CMD_VALID && acc < 2) begin
        acc_idx[acc] = k;
        acc++;
      end
      @(posedge FAB_CLK);
      #1;
      if (acc == 1) CMD_OP = 2'b10;
      if (acc == 2) CMD_VALID = 1'b0;
      k++;
    end
    CMD_VALID = 1'b0;
    chk("b2b_acc0", acc_idx[0], 0);
    chk("b2b_done0", done_idx[0], 3 + SC);
    chk("b2b_acc1", acc_idx[1], 4 + SC);
    chk("b2b_done1", done_idx[1], 7 + 2 * SC);
    chk("b2b_moves", mv, 2);
    chk("b2b_overlap", ovl, 0);
    chk("b2b_tap", int'(TAP_VAL), start_tap);

    // Reset during the 2nd MOVE of INC 3 (tap starts at 1).
    @(negedge FAB_CLK);
    CMD_VALID = 1'b1;
    CMD_OP    = 2'b01;
    CMD_COUNT = 8'd3;
    @(negedge FAB_CLK);
    CMD_VALID = 1'b0;
    mv = 0; k = 0;
    while (mv < 2 && k < 50) begin
      if (DELAY_LINE_MOVE_0) mv++;
      if (mv < 2) begin
        @(negedge FAB_CLK);
        k++;
      end
    end
    chk("mrst_moves_seen", mv, 2);
    chk("mrst_tap_before", int'(TAP_VAL), 3);
    #1;
    ARST_N = 1'b0;
    #1;
    chk("mrst_move", int'(DELAY_LINE_MOVE_0), 0);
    chk("mrst_tap", int'(TAP_VAL), 1);
    chk("mrst_ready", int'(CMD_READY), 0);
    chk("mrst_dir", int'(DELAY_LINE_DIRECTION_0), 0);
    chk("mrst_done", int'(DONE), 0);
    @(negedge FAB_CLK);
    ARST_N = 1'b1;
    @(negedge FAB_CLK);
    chk("mrst_ready_after", int'(CMD_READY), 1);
    chk("mrst_tap_after", int'(TAP_VAL), 1);
    chk("mrst_move_after", int'(DELAY_LINE_MOVE_0), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ddr4_iod_dly_ctrl.md
Name: ddr4_iod_dly_ctrl

Overview:
- Fabric-side initiator for the dynamic delay-line control port of a DDR4 PHY IOD lane. It drives DELAY_LINE_LOAD/MOVE/DIRECTION and monitors DELAY_LINE_OUT_OF_RANGE.
- Accepts load, increment and decrement commands from the training/calibration logic over a valid/ready handshake.
- Tracks the current tap value and reports completion and range errors.
- One instance per IOD lane, clocked by the same FAB_CLK as the IOD TX_CLK.

Parameters:
- TAP_W, 8, width of tap counter and command count.
- MAX_TAP, 255, highest legal tap value; moves past it are refused.
- INIT_TAP, 1, tap value after a LOAD; equals the IOD static delay value.
- SETTLE_CYC, 4, idle cycles after each LOAD/MOVE pulse before the next action or range check; legal range 1..15.

Ports:
- FAB_CLK, in, 1, fabric clock; all logic rising-edge.
- ARST_N, in, 1, asynchronous active-low reset.
- CMD_VALID, in, 1, command request.
- CMD_READY, out, 1, high in IDLE only.
- CMD_OP, in, 2, 00 LOAD, 01 INC, 10 DEC, 11 NOP.
- CMD_COUNT, in, TAP_W, number of taps for INC/DEC.
- DONE, out, 1, one-cycle pulse at command completion.
- ERR, out, 1, sticky range error for the last command.
- TAP_VAL, out, TAP_W, current tracked tap.
- DELAY_LINE_LOAD_0, out, 1, load pulse to IOD.
- DELAY_LINE_MOVE_0, out, 1, move pulse to IOD.
- DELAY_LINE_DIRECTION_0, out, 1, 1 = increase delay, 0 = decrease.
- DELAY_LINE_OUT_OF_RANGE_0, in, 1, IOD range flag.

Behaviour:
- Reset values (async on ARST_N low): state IDLE, CMD_READY 0 during reset and 1 from first clock after release, DONE 0, ERR 0, TAP_VAL = INIT_TAP, LOAD/MOVE/DIRECTION 0, internal counters 0.
- Handshake:
  - A command is accepted on a cycle where CMD_VALID && CMD_READY.
  - CMD_OP and CMD_COUNT are captured on that edge; the inputs may change afterwards.
  - CMD_READY drops the cycle after acceptance and returns high the cycle after DONE.
  - Acceptance clears ERR.
- States:
  - IDLE: waits for a command. NOP goes to DONE_ST. INC/DEC with count 0 goes to DONE_ST.
  - Range pre-check for INC/DEC (at acceptance):
    - INC: if TAP_VAL + count > MAX_TAP, go to DONE_ST with ERR=1 and no pulses. Evaluate the sum at TAP_W+1 bits.
    - DEC: if count > TAP_VAL, same refusal.
    - Otherwise go to DIR.
  - LOAD_ST: DELAY_LINE_LOAD_0 high for exactly 1 cycle, then SETTLE. TAP_VAL is set to INIT_TAP in the pulse cycle.
  - DIR: DIRECTION driven per op; hold 1 cycle for setup, then MOVE.
  - MOVE: DELAY_LINE_MOVE_0 high exactly 1 cycle. Decrement the remaining count. TAP_VAL ±1.
  - SETTLE: wait SETTLE_CYC cycles. On expiry, sample OUT_OF_RANGE:
    - If 1: set ERR=1 and undo the last TAP_VAL step. The IOD saturates, so the tracked value must equal the real tap. Go to DONE_ST; the remaining count is abandoned.
    - Else if remaining > 0: go to MOVE (DIRECTION unchanged).
    - Else: go to DONE_ST.
    - After a LOAD, OUT_OF_RANGE is ignored.
  - DONE_ST: DONE high 1 cycle, then IDLE.
- DIRECTION is held stable from DIR through the final SETTLE. In IDLE it holds its last value.
- LOAD and MOVE are never high in the same cycle.
- Latency:
  - LOAD: DONE at 2+SETTLE_CYC cycles after acceptance.
  - INC/DEC of N taps: DONE at 1+N*(1+SETTLE_CYC)+1 cycles after acceptance.
- Reset mid-operation: all outputs return to their reset values immediately. Pulses are truncated. TAP_VAL = INIT_TAP; the integrator issues a LOAD after reset to resynchronise.
- CMD_VALID while busy is ignored (not queued).

Optional Feature:
- Macro: DDR4_IOD_DLY_OOR_SYNC_EN.
- Defined:
  - DELAY_LINE_OUT_OF_RANGE_0 passes through a 2-flop synchroniser (reset 0) before use.
  - SETTLE adds 2 cycles before the sample, so INC/DEC latency per tap becomes 3+SETTLE_CYC.
- Undefined: OUT_OF_RANGE is sampled directly, with the timing given above.

Test Plan:
- Reset release then LOAD (SETTLE_CYC=4) -> LOAD_0 single pulse in cycle 1 after accept; DONE at cycle 6; TAP_VAL=1; ERR=0.
- INC count 3 from tap 1 -> DIRECTION=1; 3 MOVE pulses spaced 5 cycles apart; DONE; TAP_VAL=4.
- DEC count 5 at tap 4 -> refused with no MOVE pulses; DONE next cycle; ERR=1; TAP_VAL=4. A following NOP -> ERR cleared.
- INC count 4 at tap 10, OUT_OF_RANGE forced high after the 2nd move -> exactly 2 MOVE pulses; ERR=1; TAP_VAL=11.
- ARST_N low during the 2nd MOVE of INC count 3 -> MOVE drops immediately; TAP_VAL=1; CMD_READY=1 the first clock after release.
- CMD_VALID held high with back-to-back INC 1, DEC 1 -> the second command is accepted only after READY returns; TAP_VAL ends equal to its start value; no overlapping pulses.
